// File: rtl/axird_batch_sched.sv
// Job sequencer for the AXI data-read top: launches init/run jobs, derives the
// batch count from the byte sizes and hands each resident batch to the consumer.
module axird_batch_sched #(
    parameter int unsigned BATCH_SIZE_LOG2_LO = 16,
    parameter int unsigned BATCH_W            = 15,
    parameter int unsigned GUARD_CYCLES       = 3,
    parameter int unsigned TIMEOUT_CYCLES     = 2**20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_job_valid,
    output logic               o_job_ready,
    input  logic               i_job_cmd,
    input  logic [31:0]        i_vec_size_bytes,
    input  logic [31:0]        i_mat_size_bytes,
    output logic               o_job_done,
    output logic               o_job_err,
    output logic               o_busy,
    output logic [31:0]        o_axird_command,
    output logic               o_axird_initstart,
    output logic               o_axird_start,
    input  logic               i_axird_done,
    input  logic               i_axird_alldone,
    output logic [BATCH_W-1:0] o_data_size_batches,
    output logic               o_batch_valid,
    output logic [BATCH_W-1:0] o_batch_idx,
    input  logic               i_batch_ack
);

    localparam int unsigned SIZE_W     = 32;
    localparam int unsigned SUM_W      = SIZE_W + 1;
    localparam int unsigned DIVD_W     = SUM_W - BATCH_SIZE_LOG2_LO;
    localparam int unsigned DIV_CNT_W  = $clog2(DIVD_W);
    localparam int unsigned REM_W      = 2;
    localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GD_W       = $clog2(GUARD_CYCLES + 1);
    localparam int unsigned DWELL_RAW  = (TO_W > GD_W) ? TO_W : GD_W;
    localparam int unsigned DWELL_W    = (DWELL_RAW < 1) ? 1 : DWELL_RAW;
    localparam logic [REM_W:0] DIVISOR = (REM_W + 1)'(3);

    typedef enum logic [3:0] {
        IDLE, DIV, CHECK, LAUNCH, WAIT_BATCH, HANDOFF, NEXT, WAIT_ALL, ERR
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [SUM_W-1:0]     size_sum;
    logic [DIVD_W-1:0]    div_num;
    logic [DIVD_W-1:0]    quot;
    logic [REM_W-1:0]     rem;
    logic [REM_W:0]       trial;
    logic [DIV_CNT_W-1:0] div_cnt;
    logic                 lo_nz;
    logic [DWELL_W-1:0]   dwell;
    logic                 accept;
    logic                 size_err;
    logic                 last_batch;
    logic                 guard_ok;
    logic                 timeout;
    logic                 in_wait;

    assign size_sum   = {1'b0, i_vec_size_bytes} + {1'b0, i_mat_size_bytes};
    assign trial      = {rem, div_num[DIVD_W-1]};
    assign accept     = (state == IDLE) && i_job_valid;
    assign size_err   = lo_nz || (rem != '0) || (quot == '0) || ((quot >> BATCH_W) != '0);
    assign last_batch = (o_batch_idx == BATCH_W'(o_data_size_batches - BATCH_W'(1)));
    assign in_wait    = (state == WAIT_BATCH) || (state == WAIT_ALL);
    // done/alldone may still be stale from the previous pulse during the guard window
    assign guard_ok   = 32'(dwell) >= GUARD_CYCLES;
    assign timeout    = (TIMEOUT_CYCLES != 0) && (32'(dwell) == TIMEOUT_CYCLES - 32'd1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (i_job_valid) state_next = i_job_cmd ? DIV : LAUNCH;
            DIV:        if (div_cnt == DIV_CNT_W'(DIVD_W - 1)) state_next = CHECK;
            CHECK:      state_next = size_err ? ERR : LAUNCH;
            LAUNCH:     state_next = o_axird_command[0] ? WAIT_BATCH : WAIT_ALL;
            WAIT_BATCH: begin
                if (guard_ok && i_axird_done) state_next = HANDOFF;
                else if (timeout)             state_next = ERR;
            end
            HANDOFF:    if (i_batch_ack) state_next = last_batch ? WAIT_ALL : NEXT;
            NEXT:       state_next = WAIT_BATCH;
            WAIT_ALL: begin
                if (guard_ok && i_axird_alldone) state_next = IDLE;
                else if (timeout)                state_next = ERR;
            end
            ERR:        state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_job_ready         <= 1'b1;
            o_busy              <= 1'b0;
            o_job_done          <= 1'b0;
            o_job_err           <= 1'b0;
            o_axird_initstart   <= 1'b0;
            o_axird_start       <= 1'b0;
            o_batch_valid       <= 1'b0;
            o_axird_command     <= '0;
            o_data_size_batches <= '0;
            o_batch_idx         <= '0;
            div_num             <= '0;
            quot                <= '0;
            rem                 <= '0;
            div_cnt             <= '0;
            lo_nz               <= 1'b0;
            dwell               <= '0;
        end else begin
            o_job_ready       <= (state_next == IDLE);
            o_busy            <= (state_next != IDLE);
            o_job_done        <= (state == WAIT_ALL) && (state_next == IDLE);
            o_job_err         <= (state_next == ERR);
            o_axird_initstart <= (state_next == LAUNCH);
            o_axird_start     <= (state_next == NEXT);
            o_batch_valid     <= (state_next == HANDOFF);

            if (state_next != state)           dwell <= '0;
            else if (in_wait && dwell != '1)   dwell <= dwell + DWELL_W'(1);

            if (state_next == IDLE) o_axird_command <= '0;
            else if (accept)        o_axird_command <= 32'(i_job_cmd);

            if (accept) begin
                div_num     <= size_sum[SUM_W-1:BATCH_SIZE_LOG2_LO];
                lo_nz       <= |size_sum[BATCH_SIZE_LOG2_LO-1:0];
                quot        <= '0;
                rem         <= '0;
                div_cnt     <= '0;
                o_batch_idx <= '0;
            end

            // Restoring division by 3, MSB first, one quotient bit per cycle
            if (state == DIV) begin
                if (trial >= DIVISOR) begin
                    rem  <= REM_W'(trial - DIVISOR);
                    quot <= {quot[DIVD_W-2:0], 1'b1};
                end else begin
                    rem  <= trial[REM_W-1:0];
                    quot <= {quot[DIVD_W-2:0], 1'b0};
                end
                div_num <= div_num << 1;
                div_cnt <= div_cnt + DIV_CNT_W'(1);
            end

            if ((state == CHECK) && !size_err) o_data_size_batches <= BATCH_W'(quot);

            if ((state == HANDOFF) && i_batch_ack && !last_batch)
                o_batch_idx <= o_batch_idx + BATCH_W'(1);
        end
    end

endmodule

// File: tb/tb_axird_batch_sched.sv
// Randomized bench for axird_batch_sched with a read-top/consumer model and
// a size-arithmetic reference for batch counts and error outcomes.
module tb_axird_batch_sched;

    localparam int unsigned BW = 15;
    localparam int unsigned TO = 256;
    localparam longint unsigned BATCH_BYTES = 64'h30000;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_job_valid, i_job_cmd;
    logic [31:0]   i_vec_size_bytes, i_mat_size_bytes;
    logic          o_job_ready, o_job_done, o_job_err, o_busy;
    logic [31:0]   o_axird_command;
    logic          o_axird_initstart, o_axird_start;
    logic          i_axird_done, i_axird_alldone;
    logic [BW-1:0] o_data_size_batches, o_batch_idx;
    logic          o_batch_valid, i_batch_ack;

    int unsigned tests_run = 0, tests_failed = 0;
    int unsigned n_init = 0, n_start = 0, n_done = 0, n_err = 0, n_overlap = 0, n_cmd_bad = 0;
    logic        exp_cmd = 1'b0;
    bit          model_done_en = 1'b1;
    int unsigned done_cnt = 0;

    always #5 clk = ~clk;

    axird_batch_sched #(
        .BATCH_SIZE_LOG2_LO(16), .BATCH_W(BW), .GUARD_CYCLES(3), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_job_valid(i_job_valid), .o_job_ready(o_job_ready), .i_job_cmd(i_job_cmd),
        .i_vec_size_bytes(i_vec_size_bytes), .i_mat_size_bytes(i_mat_size_bytes),
        .o_job_done(o_job_done), .o_job_err(o_job_err), .o_busy(o_busy),
        .o_axird_command(o_axird_command), .o_axird_initstart(o_axird_initstart),
        .o_axird_start(o_axird_start), .i_axird_done(i_axird_done),
        .i_axird_alldone(i_axird_alldone), .o_data_size_batches(o_data_size_batches),
        .o_batch_valid(o_batch_valid), .o_batch_idx(o_batch_idx), .i_batch_ack(i_batch_ack)
    );

    // Pulse monitor plus read-top model: done drops on each launch and rises a few cycles later
    always @(posedge clk) begin
        #2;
        if (o_axird_initstart) n_init++;
        if (o_axird_start)     n_start++;
        if (o_job_done)        n_done++;
        if (o_job_err)         n_err++;
        if (int'(o_axird_initstart) + int'(o_axird_start) + int'(o_job_done) + int'(o_job_err) > 1)
            n_overlap++;
        if (o_busy && o_axird_command !== {31'b0, exp_cmd}) n_cmd_bad++;
        if (o_axird_initstart || o_axird_start) begin
            i_axird_done = 1'b0;
            done_cnt = $urandom_range(1, 12);
        end else if (model_done_en && done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) i_axird_done = 1'b1;
        end
    end

    task automatic send_job(input logic cmd, input logic [31:0] vec, input logic [31:0] mat);
        int n = 0;
        while (!o_job_ready && n < 1000) begin @(negedge clk); n++; end
        exp_cmd          = cmd;
        i_job_valid      = 1'b1;
        i_job_cmd        = cmd;
        i_vec_size_bytes = vec;
        i_mat_size_bytes = mat;
        @(posedge clk);
        @(negedge clk);
        i_job_valid = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++; if (o_job_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", o_job_ready); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", o_busy); end
        tests_run++; if ({o_job_done, o_job_err, o_axird_initstart, o_axird_start, o_batch_valid} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_pulses got %b want 00000", {o_job_done, o_job_err, o_axird_initstart, o_axird_start, o_batch_valid}); end
        tests_run++; if (o_axird_command !== 32'h0 || o_data_size_batches !== '0 || o_batch_idx !== '0) begin
            tests_failed++; $display("FAIL reset_values cmd=%h batches=%0d idx=%0d want 0", o_axird_command, o_data_size_batches, o_batch_idx); end
    endtask

    task automatic test_init_job();
        int unsigned i0 = n_init, s0 = n_start, d0 = n_done, c0 = n_cmd_bad;
        int n = 0;
        send_job(1'b0, $urandom, $urandom);
        while (!o_axird_initstart && n < 20) begin @(negedge clk); n++; end
        tests_run++; if (o_axird_initstart !== 1'b1) begin tests_failed++; $display("FAIL init_launch got %b want 1", o_axird_initstart); end
        repeat (50) @(negedge clk);
        i_axird_alldone = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++; if (o_job_done !== 1'b1) begin tests_failed++; $display("FAIL init_done got %b want 1", o_job_done); end
        i_axird_alldone = 1'b0;
        @(negedge clk);
        tests_run++; if (o_job_ready !== 1'b1) begin tests_failed++; $display("FAIL init_ready got %b want 1", o_job_ready); end
        tests_run++; if (n_init - i0 != 1 || n_start - s0 != 0 || n_done - d0 != 1) begin
            tests_failed++; $display("FAIL init_pulses init=%0d start=%0d done=%0d want 1 0 1", n_init - i0, n_start - s0, n_done - d0); end
        tests_run++; if (n_cmd_bad != c0) begin tests_failed++; $display("FAIL init_command bad_cycles=%0d want 0", n_cmd_bad - c0); end
    endtask

    task automatic test_run_job(input logic [31:0] vec, input logic [31:0] mat);
        longint unsigned total = longint'(vec) + longint'(mat);
        longint unsigned q     = total / BATCH_BYTES;
        bit ok = (total % BATCH_BYTES == 0) && q >= 1 && q < (64'd1 << BW);
        int unsigned i0 = n_init, s0 = n_start, d0 = n_done, e0 = n_err, o0 = n_overlap, c0 = n_cmd_bad;
        int lat = 0, n;
        send_job(1'b1, vec, mat);
        while (!(o_axird_initstart || o_job_err) && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
        tests_run++; if (lat != 18) begin tests_failed++; $display("FAIL run_latency vec=%h mat=%h got %0d want 18", vec, mat, lat); end
        if (ok) begin
            tests_run++; if (o_data_size_batches !== BW'(q)) begin
                tests_failed++; $display("FAIL run_batches vec=%h mat=%h got %0d want %0d", vec, mat, o_data_size_batches, q); end
            for (int b = 0; b < int'(q); b++) begin
                n = 0;
                while (!o_batch_valid && n < 200) begin @(negedge clk); n++; end
                tests_run++; if (o_batch_valid !== 1'b1 || o_batch_idx !== BW'(b)) begin
                    tests_failed++; $display("FAIL run_batch_valid valid=%b idx=%0d want 1 idx=%0d", o_batch_valid, o_batch_idx, b); end
                repeat ($urandom_range(0, 4)) @(negedge clk);
                i_batch_ack = 1'b1;
                @(posedge clk);
                @(negedge clk);
                i_batch_ack = 1'b0;
                tests_run++; if (o_batch_valid !== 1'b0) begin tests_failed++; $display("FAIL run_valid_drop got %b want 0", o_batch_valid); end
            end
            repeat ($urandom_range(0, 6)) @(negedge clk);
            i_axird_alldone = 1'b1;
            n = 0;
            while (!o_job_done && n < 100) begin @(negedge clk); n++; end
            tests_run++; if (o_job_done !== 1'b1) begin tests_failed++; $display("FAIL run_done got %b want 1", o_job_done); end
            i_axird_alldone = 1'b0;
            tests_run++; if (n_start - s0 != q - 1 || n_init - i0 != 1 || n_done - d0 != 1 || n_err != e0) begin
                tests_failed++; $display("FAIL run_pulses start=%0d init=%0d done=%0d err=%0d want %0d 1 1 0",
                    n_start - s0, n_init - i0, n_done - d0, n_err - e0, q - 1); end
        end else begin
            tests_run++; if (o_job_err !== 1'b1 || n_init != i0 || n_start != s0) begin
                tests_failed++; $display("FAIL run_size_err vec=%h mat=%h err=%b init=%0d start=%0d want 1 0 0",
                    vec, mat, o_job_err, n_init - i0, n_start - s0); end
        end
        @(negedge clk);
        tests_run++; if (o_job_ready !== 1'b1 || n_overlap != o0 || n_cmd_bad != c0) begin
            tests_failed++; $display("FAIL run_end ready=%b overlap=%0d cmd_bad=%0d want 1 0 0", o_job_ready, n_overlap - o0, n_cmd_bad - c0); end
    endtask

    task automatic test_size_errors();
        test_run_job(32'h0003_0000, 32'h0000_0008);
        test_run_job(32'h0004_0000, 32'h0000_0000);
        test_run_job(32'h0000_0000, 32'h0000_0000);
        test_run_job(32'hC000_0000, 32'hC000_0000);
    endtask

    task automatic test_random_runs();
        longint unsigned total;
        logic [31:0] vec;
        for (int j = 0; j < 12; j++) begin
            total = longint'($urandom_range(1, 4)) * BATCH_BYTES;
            if ($urandom_range(0, 2) == 0) total = total - BATCH_BYTES + longint'($urandom_range(1, 32'h2FFFF));
            vec = 32'($urandom_range(0, 32'(total)));
            test_run_job(vec, 32'(total - longint'(vec)));
        end
    endtask

    task automatic test_ack_stall();
        int unsigned s0, e0;
        int n = 0, bad = 0;
        send_job(1'b1, 32'h0006_0000, 32'h0);
        while (!o_batch_valid && n < 200) begin @(negedge clk); n++; end
        s0 = n_start; e0 = n_err;
        repeat (10000) begin
            @(negedge clk);
            if (o_batch_valid !== 1'b1) bad++;
        end
        tests_run++; if (bad != 0 || n_start != s0 || n_err != e0) begin
            tests_failed++; $display("FAIL stall_hold valid_low=%0d start=%0d err=%0d want 0 0 0", bad, n_start - s0, n_err - e0); end
        i_batch_ack = 1'b1; @(posedge clk); @(negedge clk); i_batch_ack = 1'b0;
        n = 0;
        while (!o_batch_valid && n < 200) begin @(negedge clk); n++; end
        tests_run++; if (o_batch_valid !== 1'b1 || o_batch_idx !== BW'(1) || n_start - s0 != 1) begin
            tests_failed++; $display("FAIL stall_second valid=%b idx=%0d starts=%0d want 1 1 1", o_batch_valid, o_batch_idx, n_start - s0); end
        i_batch_ack = 1'b1; @(posedge clk); @(negedge clk); i_batch_ack = 1'b0;
        i_axird_alldone = 1'b1;
        n = 0;
        while (!o_job_done && n < 100) begin @(negedge clk); n++; end
        tests_run++; if (o_job_done !== 1'b1) begin tests_failed++; $display("FAIL stall_done got %b want 1", o_job_done); end
        i_axird_alldone = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int unsigned s0 = n_start;
        int n;
        model_done_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            // k=0: run job stuck in WAIT_BATCH; k=1: init job stuck in WAIT_ALL
            send_job(k == 0 ? 1'b1 : 1'b0, 32'h0003_0000, 32'h0);
            n = 0;
            while (!o_axird_initstart && n < 100) begin @(negedge clk); n++; end
            @(posedge clk);
            n = 0;
            while (n < 1000) begin
                @(negedge clk);
                if (o_job_err) break;
                @(posedge clk);
                n++;
            end
            tests_run++; if (o_job_err !== 1'b1 || n != int'(TO)) begin
                tests_failed++; $display("FAIL timeout_%0d err=%b cycles=%0d want 1 %0d", k, o_job_err, n, TO); end
        end
        tests_run++; if (n_start != s0) begin tests_failed++; $display("FAIL timeout_start got %0d want 0", n_start - s0); end
        model_done_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_handoff();
        int n = 0;
        // 32767 batches: the largest count that fits BATCH_W
        send_job(1'b1, 32'hBFFE_8000, 32'hBFFE_8000);
        while (!o_batch_valid && n < 300) begin @(negedge clk); n++; end
        tests_run++; if (o_batch_valid !== 1'b1 || o_data_size_batches !== BW'(32767)) begin
            tests_failed++; $display("FAIL handoff_max valid=%b batches=%0d want 1 32767", o_batch_valid, o_data_size_batches); end
        rst = 1'b1;
        #1;
        tests_run++; if (o_job_ready !== 1'b1 || o_busy !== 1'b0 || o_batch_valid !== 1'b0 || o_axird_command !== 32'h0
                         || o_data_size_batches !== '0 || o_batch_idx !== '0) begin
            tests_failed++; $display("FAIL async_reset ready=%b busy=%b valid=%b cmd=%h batches=%0d idx=%0d want 1 0 0 0 0 0",
                o_job_ready, o_busy, o_batch_valid, o_axird_command, o_data_size_batches, o_batch_idx); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_run_job(32'h0003_0000, 32'h0003_0000);
    endtask

    initial begin
        rst = 1'b1;
        i_job_valid = 1'b0; i_job_cmd = 1'b0;
        i_vec_size_bytes = '0; i_mat_size_bytes = '0;
        i_axird_done = 1'b0; i_axird_alldone = 1'b0; i_batch_ack = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_init_job();
        test_run_job(32'h0001_0000, 32'h0005_0000);
        test_size_errors();
        test_random_runs();
        test_ack_stall();
        test_timeout();
        test_reset_handoff();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
